// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
//
// Shared out-of-order core definitions used by the reorder buffer:
//   - default widths (XLEN, REG_INDEX_WIDTH, ROB_INDEX_WIDTH) and DEPTH
//   - the ROB entry field layout (valid, ready, dest, data)
//   - the operand lookup result record and the lookup helper that applies
//     the writeback bypass rule for one read port
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

   localparam int XLEN            = 32;
   localparam int REG_INDEX_WIDTH = 5;
   localparam int ROB_INDEX_WIDTH = 4;
   localparam int DEPTH           = 2 ** ROB_INDEX_WIDTH;

   // One extra bit so that a completely full buffer (DEPTH) is representable.
   localparam int COUNT_WIDTH     = ROB_INDEX_WIDTH + 1;

   typedef logic [XLEN-1:0]            data_t;
   typedef logic [REG_INDEX_WIDTH-1:0] reg_idx_t;
   typedef logic [ROB_INDEX_WIDTH-1:0] rob_idx_t;
   typedef logic [COUNT_WIDTH-1:0]     count_t;

   localparam count_t   FULL_COUNT = count_t'(DEPTH);
   localparam count_t   COUNT_ONE  = count_t'(1);
   localparam rob_idx_t INDEX_ONE  = rob_idx_t'(1);

   // Per-entry storage. valid marks an allocated entry, ready marks that its
   // result has arrived on the writeback bus.
   typedef struct packed {
      logic     valid;
      logic     ready;
      reg_idx_t dest;
      data_t    data;
   } rob_entry_t;

   // Result of one operand lookup port.
   typedef struct packed {
      logic  ready;
      data_t data;
   } lookup_t;

   // Operand lookup for a single port. A result broadcast this very cycle to
   // an allocated entry is forwarded straight from the bus so issue logic
   // does not lose a cycle waiting for it to land in the entry.
   // Unallocated entries always report ready=0, data=0.
   function automatic lookup_t rob_lookup(
      input rob_entry_t entry,
      input rob_idx_t   idx,
      input logic       wb_valid,
      input rob_idx_t   wb_idx,
      input data_t      wb_data
   );
      lookup_t result;
      result = '0;
      if (entry.valid) begin
         if (wb_valid && (wb_idx == idx)) begin
            result.ready = 1'b1;
            result.data  = wb_data;
         end else begin
            result.ready = entry.ready;
            result.data  = entry.data;
         end
      end
      return result;
   endfunction

endpackage : reorder_buffer_pkg

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order reorder buffer sitting directly upstream of the register
// file. Allocates one entry per dispatched instruction (driving the register
// file's rename/update port), captures results from the writeback bus, and
// retires at most one oldest-ready entry per cycle through the register
// file's commit port. Two combinational lookup ports let issue logic read
// in-flight results by ROB index.
//
// Ports
//   clock               single clock, all state on the rising edge
//   reset               synchronous, active-low; overrides everything else
//   flush               synchronous squash of all in-flight entries
//   dispatch_valid      instruction requests allocation
//   dispatch_dest_reg   destination register of the dispatching instruction
//   dispatch_ready      buffer not full (combinational, current count only)
//   dispatch_ROB_index  index that would be allocated (current tail)
//   update_enable       rename write to register file (accept && dest != 0)
//   update_dest_reg     rename destination register
//   update_ROB_index    rename tag (current tail)
//   wb_valid            result broadcast valid
//   wb_ROB_index        entry the broadcast result belongs to
//   wb_data             broadcast result value
//   read_ROB1/2         operand lookup indices
//   read_ROB1/2_data    lookup data (bypassed from writeback when matching)
//   read_ROB1/2_ready   lookup entry allocated and result available
//   commit_enable       registered; retire write to register file (dest != 0)
//   commit_sel          registered destination register of retired entry
//   commit_data         registered value of retired entry
//   commit_ROB_index    registered index of retired entry
// -----------------------------------------------------------------------------
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,

   input  logic                       dispatch_valid,
   input  logic [REG_INDEX_WIDTH-1:0] dispatch_dest_reg,
   output logic                       dispatch_ready,
   output logic [ROB_INDEX_WIDTH-1:0] dispatch_ROB_index,

   output logic                       update_enable,
   output logic [REG_INDEX_WIDTH-1:0] update_dest_reg,
   output logic [ROB_INDEX_WIDTH-1:0] update_ROB_index,

   input  logic                       wb_valid,
   input  logic [ROB_INDEX_WIDTH-1:0] wb_ROB_index,
   input  logic [XLEN-1:0]            wb_data,

   input  logic [ROB_INDEX_WIDTH-1:0] read_ROB1,
   input  logic [ROB_INDEX_WIDTH-1:0] read_ROB2,
   output logic [XLEN-1:0]            read_ROB1_data,
   output logic [XLEN-1:0]            read_ROB2_data,
   output logic                       read_ROB1_ready,
   output logic                       read_ROB2_ready,

   output logic                       commit_enable,
   output logic [REG_INDEX_WIDTH-1:0] commit_sel,
   output logic [XLEN-1:0]            commit_data,
   output logic [ROB_INDEX_WIDTH-1:0] commit_ROB_index
);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   rob_entry_t entries [DEPTH];
   rob_idx_t   head;
   rob_idx_t   tail;
   count_t     count;

   // --------------------------------------------------------------------------
   // Control decode
   // --------------------------------------------------------------------------
   logic       accept;
   logic       commit_fire;
   logic       wb_hit;
   rob_entry_t head_entry;
   lookup_t    lookup1;
   lookup_t    lookup2;

   // NOTE: every signal driven here gets a value on every path through the
   // block, so no storage (latch) is implied for combinational outputs.
   always_comb begin
      // Full is judged from the current count only: a retirement in this
      // cycle does not open a slot for this cycle's dispatch.
      dispatch_ready     = (count != FULL_COUNT);
      dispatch_ROB_index = tail;

      // Flush squashes any dispatch in the same cycle, including its rename.
      accept             = dispatch_valid && dispatch_ready && !flush;
      update_enable      = accept && (dispatch_dest_reg != '0);
      update_dest_reg    = dispatch_dest_reg;
      update_ROB_index   = tail;

      head_entry         = entries[head];
      commit_fire        = head_entry.valid && head_entry.ready;

      // Writeback only lands in an already-allocated entry; a broadcast that
      // targets the slot being allocated this cycle is dropped.
      wb_hit             = wb_valid && entries[wb_ROB_index].valid;
   end

   // --------------------------------------------------------------------------
   // Operand lookup ports
   // --------------------------------------------------------------------------
   always_comb begin
      lookup1 = rob_lookup(entries[read_ROB1], read_ROB1,
                           wb_valid, wb_ROB_index, wb_data);
      lookup2 = rob_lookup(entries[read_ROB2], read_ROB2,
                           wb_valid, wb_ROB_index, wb_data);
   end

   assign read_ROB1_ready = lookup1.ready;
   assign read_ROB1_data  = lookup1.data;
   assign read_ROB2_ready = lookup2.ready;
   assign read_ROB2_data  = lookup2.data;

   // --------------------------------------------------------------------------
   // Sequential state: pointers, entries, registered commit port
   // --------------------------------------------------------------------------
   // NOTE: all state here is updated with non-blocking assignments so every
   // read in this block sees the pre-edge value; the order of the writeback,
   // retire and allocate statements below only matters where they touch the
   // same entry field, and then the later statement wins.
   always_ff @(posedge clock) begin
      if (!reset || flush) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         commit_enable <= 1'b0;
         // NOTE: only the valid/ready flags of the entry array are cleared;
         // dest/data are never read while valid=0, so they carry no reset and
         // can map onto plain storage.
         for (int i = 0; i < DEPTH; i++) begin
            entries[i].valid <= 1'b0;
            entries[i].ready <= 1'b0;
         end
         // A squash only silences the commit port; a full reset zeroes it.
         if (!reset) begin
            commit_sel       <= '0;
            commit_data      <= '0;
            commit_ROB_index <= '0;
         end
      end else begin
         // Result capture. A repeated broadcast to the same entry simply
         // overwrites the previous value.
         if (wb_hit) begin
            entries[wb_ROB_index].ready <= 1'b1;
            entries[wb_ROB_index].data  <= wb_data;
         end

         // In-order retirement of the oldest entry. The commit port always
         // reports the pre-edge contents, so a writeback racing a retirement
         // of the same entry does not alter what is committed.
         commit_enable <= commit_fire && (head_entry.dest != '0);
         if (commit_fire) begin
            entries[head].valid <= 1'b0;
            head                <= head + INDEX_ONE;
            commit_sel          <= head_entry.dest;
            commit_data         <= head_entry.data;
            commit_ROB_index    <= head;
         end

         // Allocation at the tail. The tail slot is never valid when a
         // dispatch is accepted, so it cannot collide with the writeback
         // above, and it equals head only when the buffer is empty, in which
         // case no retirement happens.
         if (accept) begin
            entries[tail].valid <= 1'b1;
            entries[tail].ready <= 1'b0;
            entries[tail].dest  <= dispatch_dest_reg;
            tail                <= tail + INDEX_ONE;
         end

         // Dispatch and retirement in the same cycle cancel out.
         unique case ({accept, commit_fire})
            2'b10:   count <= count + COUNT_ONE;
            2'b01:   count <= count - COUNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule : reorder_buffer

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer. A reference model of the buffer is
// stepped at every clock edge; whenever the model predicts a visible
// retirement it pushes the expected commit record onto a scoreboard queue,
// and the record is popped and compared when the DUT raises commit_enable.
// Each scenario task also makes its own inline comparisons of the
// combinational outputs.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic     clock;
   logic     reset;
   logic     flush;
   logic     dispatch_valid;
   reg_idx_t dispatch_dest_reg;
   logic     dispatch_ready;
   rob_idx_t dispatch_ROB_index;
   logic     update_enable;
   reg_idx_t update_dest_reg;
   rob_idx_t update_ROB_index;
   logic     wb_valid;
   rob_idx_t wb_ROB_index;
   data_t    wb_data;
   rob_idx_t read_ROB1;
   rob_idx_t read_ROB2;
   data_t    read_ROB1_data;
   data_t    read_ROB2_data;
   logic     read_ROB1_ready;
   logic     read_ROB2_ready;
   logic     commit_enable;
   reg_idx_t commit_sel;
   data_t    commit_data;
   rob_idx_t commit_ROB_index;

   reorder_buffer dut (
      .clock              (clock),
      .reset              (reset),
      .flush              (flush),
      .dispatch_valid     (dispatch_valid),
      .dispatch_dest_reg  (dispatch_dest_reg),
      .dispatch_ready     (dispatch_ready),
      .dispatch_ROB_index (dispatch_ROB_index),
      .update_enable      (update_enable),
      .update_dest_reg    (update_dest_reg),
      .update_ROB_index   (update_ROB_index),
      .wb_valid           (wb_valid),
      .wb_ROB_index       (wb_ROB_index),
      .wb_data            (wb_data),
      .read_ROB1          (read_ROB1),
      .read_ROB2          (read_ROB2),
      .read_ROB1_data     (read_ROB1_data),
      .read_ROB2_data     (read_ROB2_data),
      .read_ROB1_ready    (read_ROB1_ready),
      .read_ROB2_ready    (read_ROB2_ready),
      .commit_enable      (commit_enable),
      .commit_sel         (commit_sel),
      .commit_data        (commit_data),
      .commit_ROB_index   (commit_ROB_index)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int commits_seen = 0;

   typedef struct {
      reg_idx_t sel;
      data_t    data;
      rob_idx_t idx;
   } commit_t;

   commit_t sb [$];

   // Reference model state
   logic     m_valid [DEPTH];
   logic     m_ready [DEPTH];
   reg_idx_t m_dest  [DEPTH];
   data_t    m_data  [DEPTH];
   int       m_head;
   int       m_tail;
   int       m_count;

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         m_valid[i] = 1'b0;
         m_ready[i] = 1'b0;
      end
      m_head  = 0;
      m_tail  = 0;
      m_count = 0;
   endtask

   task automatic set_idle();
      reset             = 1'b1;
      flush             = 1'b0;
      dispatch_valid    = 1'b0;
      dispatch_dest_reg = '0;
      wb_valid          = 1'b0;
      wb_ROB_index      = '0;
      wb_data           = '0;
      read_ROB1         = '0;
      read_ROB2         = '0;
   endtask

   // Advance one clock: step the model with the inputs currently applied,
   // let the edge happen, then score the registered commit port.
   task automatic tick();
      commit_t exp_c;
      commit_t got_c;
      if (!reset || flush) begin
         model_clear();
      end else begin
         logic acc;
         logic cf;
         int   h;
         acc = dispatch_valid && (m_count != DEPTH);
         h   = m_head;
         cf  = m_valid[h] && m_ready[h];
         if (cf && (m_dest[h] != '0)) begin
            exp_c.sel  = m_dest[h];
            exp_c.data = m_data[h];
            exp_c.idx  = rob_idx_t'(h);
            sb.push_back(exp_c);
         end
         if (wb_valid && m_valid[int'(wb_ROB_index)]) begin
            m_ready[int'(wb_ROB_index)] = 1'b1;
            m_data[int'(wb_ROB_index)]  = wb_data;
         end
         if (cf) begin
            m_valid[h] = 1'b0;
            m_head     = (h + 1) % DEPTH;
            m_count    = m_count - 1;
         end
         if (acc) begin
            m_valid[m_tail] = 1'b1;
            m_ready[m_tail] = 1'b0;
            m_dest[m_tail]  = dispatch_dest_reg;
            m_tail          = (m_tail + 1) % DEPTH;
            m_count         = m_count + 1;
         end
      end
      @(posedge clock);
      #1;
      if (commit_enable === 1'b1) begin
         commits_seen++;
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_commit got sel=%0d data=%0h idx=%0d exp no commit",
                     commit_sel, commit_data, commit_ROB_index);
         end else begin
            exp_c = sb.pop_front();
            got_c.sel  = commit_sel;
            got_c.data = commit_data;
            got_c.idx  = commit_ROB_index;
            if ({got_c.sel, got_c.data, got_c.idx} !== {exp_c.sel, exp_c.data, exp_c.idx}) begin
               failures++;
               $display("FAIL commit_record got sel=%0d data=%0h idx=%0d exp sel=%0d data=%0h idx=%0d",
                        got_c.sel, got_c.data, got_c.idx, exp_c.sel, exp_c.data, exp_c.idx);
            end
         end
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL missing_commit got commit_enable=%0b exp commit of idx=%0d",
                  commit_enable, sb[0].idx);
         sb.delete();
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      set_idle();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      checks++;
      if (dispatch_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_dispatch_ready got=%0b exp=1", dispatch_ready);
      end
      checks++;
      if (dispatch_ROB_index !== rob_idx_t'(0)) begin
         failures++;
         $display("FAIL reset_dispatch_index got=%0d exp=0", dispatch_ROB_index);
      end
      checks++;
      if ({commit_enable, commit_sel, commit_data, commit_ROB_index} !== '0) begin
         failures++;
         $display("FAIL reset_commit_port got en=%0b sel=%0d data=%0h idx=%0d exp all 0",
                  commit_enable, commit_sel, commit_data, commit_ROB_index);
      end
      checks++;
      if (read_ROB1_ready !== 1'b0 || read_ROB1_data !== '0) begin
         failures++;
         $display("FAIL reset_lookup got ready=%0b data=%0h exp ready=0 data=0",
                  read_ROB1_ready, read_ROB1_data);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_dispatch();
      for (int i = 0; i < 3; i++) begin
         dispatch_valid    = 1'b1;
         dispatch_dest_reg = reg_idx_t'(i + 1);
         #1;
         checks++;
         if (dispatch_ROB_index !== rob_idx_t'(i)) begin
            failures++;
            $display("FAIL dispatch_index got=%0d exp=%0d", dispatch_ROB_index, i);
         end
         checks++;
         if ({update_enable, update_dest_reg, update_ROB_index} !==
             {1'b1, reg_idx_t'(i + 1), rob_idx_t'(i)}) begin
            failures++;
            $display("FAIL dispatch_update got en=%0b dest=%0d idx=%0d exp en=1 dest=%0d idx=%0d",
                     update_enable, update_dest_reg, update_ROB_index, i + 1, i);
         end
         tick();
      end
      dispatch_valid = 1'b0;
      #1;
      checks++;
      if (dispatch_ROB_index !== rob_idx_t'(3) || dispatch_ready !== 1'b1) begin
         failures++;
         $display("FAIL dispatch_after3 got idx=%0d ready=%0b exp idx=3 ready=1",
                  dispatch_ROB_index, dispatch_ready);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_writeback_order();
      // Younger entry completes first (twice, second value wins).
      wb_valid = 1'b1; wb_ROB_index = 4'd1; wb_data = 32'd29;
      tick();
      wb_data = 32'd30;
      tick();
      wb_ROB_index = 4'd0; wb_data = 32'd15;
      read_ROB1 = 4'd1;
      read_ROB2 = 4'd2;
      #1;
      checks++;
      if (read_ROB1_ready !== 1'b1 || read_ROB1_data !== 32'd30) begin
         failures++;
         $display("FAIL lookup_stored got ready=%0b data=%0d exp ready=1 data=30",
                  read_ROB1_ready, read_ROB1_data);
      end
      checks++;
      if (read_ROB2_ready !== 1'b0) begin
         failures++;
         $display("FAIL lookup_pending got ready=%0b exp=0", read_ROB2_ready);
      end
      tick();
      wb_valid = 1'b0;
      checks++;
      if (commit_enable !== 1'b0) begin
         failures++;
         $display("FAIL no_bypass_commit got=%0b exp=0", commit_enable);
      end
      tick();
      checks++;
      if (commit_enable !== 1'b1 || commit_ROB_index !== rob_idx_t'(0)) begin
         failures++;
         $display("FAIL commit_oldest got en=%0b idx=%0d exp en=1 idx=0",
                  commit_enable, commit_ROB_index);
      end
      tick();
      checks++;
      if (commit_enable !== 1'b1 || commit_ROB_index !== rob_idx_t'(1)) begin
         failures++;
         $display("FAIL commit_second got en=%0b idx=%0d exp en=1 idx=1",
                  commit_enable, commit_ROB_index);
      end
      tick();
      checks++;
      if (commit_enable !== 1'b0) begin
         failures++;
         $display("FAIL commit_not_ready got=%0b exp=0", commit_enable);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_lookup();
      // Entry 2 is allocated but not yet written back.
      read_ROB1 = 4'd2;
      read_ROB2 = 4'd5;
      wb_valid = 1'b1; wb_ROB_index = 4'd2; wb_data = 32'd77;
      #1;
      checks++;
      if (read_ROB1_ready !== 1'b1 || read_ROB1_data !== 32'd77) begin
         failures++;
         $display("FAIL lookup_bypass got ready=%0b data=%0d exp ready=1 data=77",
                  read_ROB1_ready, read_ROB1_data);
      end
      checks++;
      if (read_ROB2_ready !== 1'b0 || read_ROB2_data !== '0) begin
         failures++;
         $display("FAIL lookup_unallocated got ready=%0b data=%0h exp ready=0 data=0",
                  read_ROB2_ready, read_ROB2_data);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      checks++;
      if (read_ROB1_ready !== 1'b1 || read_ROB1_data !== 32'd77) begin
         failures++;
         $display("FAIL lookup_landed got ready=%0b data=%0d exp ready=1 data=77",
                  read_ROB1_ready, read_ROB1_data);
      end
      tick();
      checks++;
      if (read_ROB1_ready !== 1'b0) begin
         failures++;
         $display("FAIL lookup_retired got ready=%0b exp=0", read_ROB1_ready);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_dest_zero();
      dispatch_valid = 1'b1; dispatch_dest_reg = '0;
      #1;
      checks++;
      if (update_enable !== 1'b0 || dispatch_ROB_index !== rob_idx_t'(3)) begin
         failures++;
         $display("FAIL dest0_update got en=%0b idx=%0d exp en=0 idx=3",
                  update_enable, dispatch_ROB_index);
      end
      tick();
      dispatch_valid = 1'b0;
      wb_valid = 1'b1; wb_ROB_index = 4'd3; wb_data = 32'd99;
      tick();
      // Allocate entry 4 while a result aimed at it is on the bus: dropped.
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'd5;
      wb_ROB_index = 4'd4; wb_data = 32'd44;
      tick();
      checks++;
      if (commit_enable !== 1'b0) begin
         failures++;
         $display("FAIL dest0_silent got=%0b exp=0", commit_enable);
      end
      dispatch_valid = 1'b0;
      wb_data = 32'd55;
      tick();
      wb_valid = 1'b0;
      tick();
      checks++;
      if (commit_enable !== 1'b1 || commit_ROB_index !== rob_idx_t'(4) || commit_data !== 32'd55) begin
         failures++;
         $display("FAIL dest0_head_advance got en=%0b idx=%0d data=%0d exp en=1 idx=4 data=55",
                  commit_enable, commit_ROB_index, commit_data);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_full_wrap();
      // Head = tail = 5, empty. Sixteen allocations walk the tail through 15 -> 0.
      for (int i = 0; i < DEPTH; i++) begin
         dispatch_valid = 1'b1; dispatch_dest_reg = reg_idx_t'(i + 1);
         #1;
         checks++;
         if (dispatch_ready !== 1'b1 || dispatch_ROB_index !== rob_idx_t'((5 + i) % DEPTH)) begin
            failures++;
            $display("FAIL fill_index got ready=%0b idx=%0d exp ready=1 idx=%0d",
                     dispatch_ready, dispatch_ROB_index, (5 + i) % DEPTH);
         end
         tick();
      end
      dispatch_valid = 1'b0;
      #1;
      checks++;
      if (dispatch_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_ready got=%0b exp=0", dispatch_ready);
      end
      wb_valid = 1'b1; wb_ROB_index = 4'd5; wb_data = 32'h500;
      tick();
      wb_valid = 1'b0;
      // Retirement this cycle must not open a slot for this cycle's dispatch.
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'd20;
      #1;
      checks++;
      if (dispatch_ready !== 1'b0 || update_enable !== 1'b0) begin
         failures++;
         $display("FAIL full_commit_dispatch got ready=%0b upd=%0b exp ready=0 upd=0",
                  dispatch_ready, update_enable);
      end
      tick();
      #1;
      checks++;
      if (dispatch_ready !== 1'b1 || dispatch_ROB_index !== rob_idx_t'(5)) begin
         failures++;
         $display("FAIL after_free got ready=%0b idx=%0d exp ready=1 idx=5",
                  dispatch_ready, dispatch_ROB_index);
      end
      checks++;
      if (update_enable !== 1'b1 || update_ROB_index !== rob_idx_t'(5)) begin
         failures++;
         $display("FAIL refill_update got en=%0b idx=%0d exp en=1 idx=5",
                  update_enable, update_ROB_index);
      end
      tick();
      dispatch_valid = 1'b0;
      #1;
      checks++;
      if (dispatch_ready !== 1'b0) begin
         failures++;
         $display("FAIL refull_ready got=%0b exp=0", dispatch_ready);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 5; i++) begin
         dispatch_valid = 1'b1; dispatch_dest_reg = reg_idx_t'(10 + i);
         tick();
      end
      dispatch_valid = 1'b0;
      wb_valid = 1'b1; wb_ROB_index = 4'd0; wb_data = 32'h11;
      tick();
      wb_valid = 1'b0;
      // Head is ready to retire at this edge; flush and a dispatch coincide.
      flush = 1'b1;
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'd9;
      #1;
      checks++;
      if (update_enable !== 1'b0) begin
         failures++;
         $display("FAIL flush_update got=%0b exp=0", update_enable);
      end
      tick();
      flush = 1'b0;
      dispatch_valid = 1'b0;
      read_ROB1 = 4'd0;
      #1;
      checks++;
      if (commit_enable !== 1'b0 || dispatch_ready !== 1'b1 || dispatch_ROB_index !== rob_idx_t'(0)) begin
         failures++;
         $display("FAIL flush_state got en=%0b ready=%0b idx=%0d exp en=0 ready=1 idx=0",
                  commit_enable, dispatch_ready, dispatch_ROB_index);
      end
      checks++;
      if (read_ROB1_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_lookup got=%0b exp=0", read_ROB1_ready);
      end
      tick();
      // Head restarted at 0.
      dispatch_valid = 1'b1; dispatch_dest_reg = 5'd7;
      tick();
      dispatch_valid = 1'b0;
      wb_valid = 1'b1; wb_ROB_index = 4'd0; wb_data = 32'h70;
      tick();
      wb_valid = 1'b0;
      tick();
      checks++;
      if (commit_enable !== 1'b1 || commit_sel !== 5'd7 || commit_ROB_index !== rob_idx_t'(0)) begin
         failures++;
         $display("FAIL flush_head_zero got en=%0b sel=%0d idx=%0d exp en=1 sel=7 idx=0",
                  commit_enable, commit_sel, commit_ROB_index);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset_midstream();
      for (int i = 0; i < 3; i++) begin
         dispatch_valid = 1'b1; dispatch_dest_reg = reg_idx_t'(11 + i);
         tick();
      end
      dispatch_valid = 1'b0;
      wb_valid = 1'b1; wb_ROB_index = 4'd1; wb_data = 32'hAB;
      tick();
      wb_valid = 1'b0;
      reset = 1'b0;
      dispatch_valid = 1'b1;
      tick();
      reset = 1'b1;
      dispatch_valid = 1'b0;
      read_ROB1 = 4'd1;
      #1;
      checks++;
      if ({commit_enable, commit_sel, commit_data, commit_ROB_index} !== '0) begin
         failures++;
         $display("FAIL midreset_commit got en=%0b sel=%0d data=%0h idx=%0d exp all 0",
                  commit_enable, commit_sel, commit_data, commit_ROB_index);
      end
      checks++;
      if (dispatch_ready !== 1'b1 || dispatch_ROB_index !== rob_idx_t'(0) || read_ROB1_ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset_state got ready=%0b idx=%0d lookup=%0b exp ready=1 idx=0 lookup=0",
                  dispatch_ready, dispatch_ROB_index, read_ROB1_ready);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_back_to_back();
      int start_commits;
      start_commits = commits_seen;
      for (int i = 0; i < 24; i++) begin
         dispatch_valid    = 1'b1;
         dispatch_dest_reg = reg_idx_t'($urandom_range(31, 1));
         wb_valid          = (i != 0);
         wb_ROB_index      = rob_idx_t'((m_tail + DEPTH - 1) % DEPTH);
         wb_data           = data_t'($urandom);
         tick();
      end
      dispatch_valid = 1'b0;
      wb_valid       = 1'b1;
      wb_ROB_index   = rob_idx_t'((m_tail + DEPTH - 1) % DEPTH);
      wb_data        = data_t'($urandom);
      tick();
      wb_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (commits_seen - start_commits !== 24) begin
         failures++;
         $display("FAIL stream_commit_count got=%0d exp=24", commits_seen - start_commits);
      end
   endtask

   // -------------------------------------------------------------------------
   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_clear();
      test_reset();
      test_dispatch();
      test_writeback_order();
      test_lookup();
      test_dest_zero();
      test_full_wrap();
      test_flush();
      test_reset_midstream();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_reorder_buffer

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the out-of-order core; sits directly upstream of register_file.
- Allocates one entry per dispatched instruction and drives register_file's update port (rename).
- Captures results from the writeback bus and retires the oldest ready entry each cycle through register_file's commit port.
- Provides two operand lookup ports so issue logic can read in-flight results by ROB index.

Parameters:
- XLEN, 32, data width of results.
- REG_INDEX_WIDTH, 5, architectural register selector width.
- ROB_INDEX_WIDTH, 4, entry index width; DEPTH = 2**ROB_INDEX_WIDTH (16).

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-low reset; state clears on the rising edge where reset==0.
- flush  input  1  synchronous squash of all entries.
- dispatch_valid  input  1  an instruction requests allocation.
- dispatch_dest_reg  input  REG_INDEX_WIDTH  destination register of the dispatching instruction.
- dispatch_ready  output  1  entry available, i.e. !full; combinational.
- dispatch_ROB_index  output  ROB_INDEX_WIDTH  index allocated (current tail).
- update_enable  output  1  drives register_file.update_enable.
- update_dest_reg  output  REG_INDEX_WIDTH  drives register_file.update_dest_reg.
- update_ROB_index  output  ROB_INDEX_WIDTH  drives register_file.update_ROB_index (zero-extended at the register_file boundary if widths differ).
- wb_valid  input  1  result broadcast valid.
- wb_ROB_index  input  ROB_INDEX_WIDTH  entry the result belongs to.
- wb_data  input  XLEN  result value.
- read_ROB1 / read_ROB2  input  ROB_INDEX_WIDTH  operand lookup indices.
- read_ROB1_data / read_ROB2_data  output  XLEN  entry data.
- read_ROB1_ready / read_ROB2_ready  output  1  entry valid and result available.
- commit_enable  output  1  registered; drives register_file.commit_enable.
- commit_sel  output  REG_INDEX_WIDTH  registered destination register.
- commit_data  output  XLEN  registered committed value.
- commit_ROB_index  output  ROB_INDEX_WIDTH  registered index of the retired entry.

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-low.
- State: head, tail (ROB_INDEX_WIDTH bits, wrap modulo DEPTH), count (ROB_INDEX_WIDTH+1 bits); per-entry valid, ready, dest, data.
- Reset (reset==0 at edge):
  - head=tail=count=0; all valid/ready=0.
  - commit_* = 0.
  - Afterwards dispatch_ready=1, dispatch_ROB_index=0.
  - Reset overrides flush, dispatch, writeback and commit.
- Dispatch:
  - Accepted when dispatch_valid && dispatch_ready.
  - At the edge, entry[tail] gets valid=1, ready=0, dest=dispatch_dest_reg; tail++; count++.
  - update_enable = accept && dest!=0 (combinational, same cycle).
  - update_dest_reg = dispatch_dest_reg; update_ROB_index = tail.
- Full / empty:
  - dispatch_ready = (count != DEPTH), computed from current count only.
  - A commit in the same cycle does not free a slot for that cycle's dispatch.
- Writeback:
  - If wb_valid and entry[wb_ROB_index].valid, set ready=1 and data=wb_data at the edge.
  - Writeback to an invalid entry is ignored.
  - A duplicate writeback overwrites data.
- Commit:
  - Condition: entry[head].valid && entry[head].ready at the edge.
  - On commit: entry[head].valid=0; head++; count--.
  - Next cycle commit_enable = (dest!=0), with commit_sel=dest, commit_data=data, commit_ROB_index=old head.
  - Otherwise commit_enable=0 next cycle.
  - At most one commit per cycle.
  - Entries with dest 0 retire silently.
- Writeback to the head entry in cycle N makes it ready at edge N; it commits at edge N+1 and commit_enable is seen in cycle N+1→N+2. No same-cycle writeback→commit bypass.
- Simultaneous dispatch + commit: count unchanged, both pointers advance.
- Simultaneous dispatch + writeback to the tail index: the writeback is ignored (entry not yet valid).
- Operand lookup (combinational):
  - If wb_valid && wb_ROB_index==read_ROBx && entry valid: ready=1, data=wb_data (bypass).
  - Else: ready = valid && ready, data = entry data.
  - An invalid entry returns ready=0, data=0.
- Flush:
  - At the edge, clears all valid/ready; head=tail=count=0; commit_enable=0 next cycle.
  - Overrides dispatch, writeback and commit in that cycle.
  - update_enable is forced 0 while flush=1.

Decomposition:
- Shared out-of-order package holds:
  - XLEN, REG_INDEX_WIDTH and ROB_INDEX_WIDTH defaults;
  - the ROB entry field layout (valid, ready, dest, data);
  - the DEPTH derivation.
- Single module; no sub-module is warranted (pointer logic is three counters).

Test Plan:
- Reset then dispatch dest 1, 2, 3 on consecutive cycles → dispatch_ROB_index 0, 1, 2; update_enable=1 with update_ROB_index 0, 1, 2; count=3.
- Writeback idx1=30, then idx0=15 → commit_sel 1/data 15/ROB 0, then next cycle commit_sel 2/data 30/ROB 1; idx2 stays uncommitted; no out-of-order commit.
- Fill 16 entries → dispatch_ready=0. Dispatch plus commit in the same cycle → dispatch rejected. Next cycle dispatch_ready=1; tail wraps to 0 on the next allocation.
- Dispatch dest 0, write back 99 → entry retires, commit_enable stays 0, head advances.
- Lookup read_ROB1=idx2 while wb_valid idx2 data 77 → read_ROB1_ready=1, data 77 same cycle. Unallocated index → ready=0.
- Flush with 5 entries in flight, plus a simultaneous dispatch → count=0, head=tail=0, no commit_enable. Drive reset=0 mid-stream → same cleared state.
